// File: rtl/lab_access_ctrl_if.sv
// Card-reader command bus and per-lab door/status outputs of lab_access_ctrl.
// The master drives commands; the slave (controller) drives counts and indications.
interface lab_access_ctrl_if #(
  parameter int unsigned NUM_LABS = 2,
  parameter int unsigned CAP      = 30,
  parameter int unsigned CODE_W   = 5
) ();
  localparam int unsigned CNT_W = $clog2(CAP + 1);
  localparam int unsigned SEL_W = (NUM_LABS > 1) ? $clog2(NUM_LABS) : 1;

  logic [CODE_W-1:0]         smartCode;
  logic [SEL_W-1:0]          labSel;
  logic [1:0]                mode;
  logic [NUM_LABS*CNT_W-1:0] numOfStu;
  logic [NUM_LABS-1:0]       unlock;
  logic [NUM_LABS-1:0]       restrictionWarn;
  logic [NUM_LABS-1:0]       fullWarn;
  logic [NUM_LABS-1:0]       exitErr;
  logic                      selErr;
  logic [NUM_LABS-1:0]       isFull;
  logic [NUM_LABS-1:0]       isEmpty;

  modport master (
    output smartCode, labSel, mode,
    input  numOfStu, unlock, restrictionWarn, fullWarn, exitErr, selErr, isFull, isEmpty
  );

  modport slave (
    input  smartCode, labSel, mode,
    output numOfStu, unlock, restrictionWarn, fullWarn, exitErr, selErr, isFull, isEmpty
  );
endinterface

// File: rtl/lab_access_ctrl.sv
// Multi-lab occupancy/door controller: one enter/exit/clear command per cycle on lab labSel.
// Optional parity restriction above FREE_CAP is enabled by defining LAB_ACCESS_RESTRICT_EN.
module lab_access_ctrl #(
  parameter int unsigned NUM_LABS = 2,
  parameter int unsigned CAP      = 30,
  parameter int unsigned FREE_CAP = 15,
  parameter int unsigned CODE_W   = 5
) (
  input  logic             CLK,
  input  logic             RST_N,
  lab_access_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(CAP + 1);
  localparam int unsigned SEL_W = (NUM_LABS > 1) ? $clog2(NUM_LABS) : 1;
`ifdef LAB_ACCESS_RESTRICT_EN
  localparam bit RESTRICT_EN = 1'b1;
`else
  localparam bit RESTRICT_EN = 1'b0;
`endif
  // Below this count entry is unconditional; with the rule disabled it reaches CAP.
  localparam int unsigned OPEN_LIM = RESTRICT_EN ? FREE_CAP : CAP;

  typedef enum logic [1:0] {
    MODE_EXIT  = 2'b00,
    MODE_ENTER = 2'b01,
    MODE_IDLE  = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  typedef logic [CNT_W-1:0] cnt_t;

  cnt_t                cnt_q [NUM_LABS];
  cnt_t                cnt_d [NUM_LABS];
  logic [NUM_LABS-1:0] unlock_q, unlock_d;
  logic [NUM_LABS-1:0] restr_warn_q, restr_warn_d;
  logic [NUM_LABS-1:0] full_warn_q, full_warn_d;
  logic [NUM_LABS-1:0] exit_err_q, exit_err_d;
  logic                sel_err_q, sel_err_d;
  logic [NUM_LABS-1:0] is_full_q, is_full_d;
  logic [NUM_LABS-1:0] is_empty_q, is_empty_d;
  logic                parity;
  mode_e               cmd;
  logic [NUM_LABS*CNT_W-1:0] num_of_stu;

  always_comb begin
    cnt_d        = cnt_q;
    unlock_d     = '0;
    restr_warn_d = '0;
    full_warn_d  = '0;
    exit_err_d   = '0;
    sel_err_d    = 1'b0;
    parity       = ^bus.smartCode;
    cmd          = mode_e'(bus.mode);

    if (cmd != MODE_IDLE) begin
      if ({1'b0, bus.labSel} >= (SEL_W + 1)'(NUM_LABS)) begin
        sel_err_d = 1'b1;
      end else begin
        for (int unsigned i = 0; i < NUM_LABS; i++) begin
          if (bus.labSel == SEL_W'(i)) begin
            unique case (cmd)
              MODE_ENTER: begin
                if (cnt_q[i] == CNT_W'(CAP)) begin
                  full_warn_d[i] = 1'b1;
                end else if (cnt_q[i] < CNT_W'(OPEN_LIM) || parity != i[0]) begin
                  cnt_d[i]    = cnt_q[i] + CNT_W'(1);
                  unlock_d[i] = 1'b1;
                end else begin
                  restr_warn_d[i] = 1'b1;
                end
              end
              MODE_EXIT: begin
                if (cnt_q[i] != '0) begin
                  cnt_d[i]    = cnt_q[i] - CNT_W'(1);
                  unlock_d[i] = 1'b1;
                end else begin
                  exit_err_d[i] = 1'b1;
                end
              end
              MODE_CLEAR: cnt_d[i] = '0;
              default: ;
            endcase
          end
        end
      end
    end

    // Flags are derived from the next count so they stay aligned with numOfStu.
    for (int unsigned i = 0; i < NUM_LABS; i++) begin
      is_full_d[i]  = (cnt_d[i] == CNT_W'(CAP));
      is_empty_d[i] = (cnt_d[i] == '0);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q        <= '{default: '0};
      unlock_q     <= '0;
      restr_warn_q <= '0;
      full_warn_q  <= '0;
      exit_err_q   <= '0;
      sel_err_q    <= 1'b0;
      is_full_q    <= '0;
      is_empty_q   <= '1;
    end else begin
      cnt_q        <= cnt_d;
      unlock_q     <= unlock_d;
      restr_warn_q <= restr_warn_d;
      full_warn_q  <= full_warn_d;
      exit_err_q   <= exit_err_d;
      sel_err_q    <= sel_err_d;
      is_full_q    <= is_full_d;
      is_empty_q   <= is_empty_d;
    end
  end

  always_comb begin
    num_of_stu = '0;
    for (int unsigned i = 0; i < NUM_LABS; i++) begin
      num_of_stu[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign bus.numOfStu        = num_of_stu;
  assign bus.unlock          = unlock_q;
  assign bus.restrictionWarn = RESTRICT_EN ? restr_warn_q : '0;
  assign bus.fullWarn        = full_warn_q;
  assign bus.exitErr         = exit_err_q;
  assign bus.selErr          = sel_err_q;
  assign bus.isFull          = is_full_q;
  assign bus.isEmpty         = is_empty_q;
endmodule
